mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Iterative multiply/divide sequencer for the RV32M extension. It is instantiated beside the execute stage. It accepts one M-type operation, latches the operands, and runs a shift-add multiply or a restoring divide over XLEN cycles. It then presents the result for one cycle and drives the execute-stage stall request meanwhile. Sign handling, RISC-V divide-by-zero/overflow rules and pipeline flush abort are owned here.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous reset, active-low.
start_i  in  1  M-type instruction present in execute; level, held while stalled.
flush_i  in  1  pipeline flush (jump/branch taken ahead); aborts operation.
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op1_i  in  XLEN  rs1 value.
op2_i  in  XLEN  rs2 value.
busy_o  out  1  state is BUSY.
ready_o  out  1  result_o valid; single-cycle pulse (DONE state).
result_o  out  XLEN  selected result word.
stallreq_o  out  1  stall request to pipeline control.

Behaviour:
- Reset (rst_i low, async): state IDLE, counter 0, all internal regs 0; busy_o=0, ready_o=0, result_o=0, stallreq_o=0.
- States: IDLE, BUSY, DONE.
- IDLE: start_i=1 and flush_i=0 at an edge:
  - latch funct3, |op1|, |op2| (abs only for signed-interpreted operands: MULH both, MULHSU op1 only, DIV/REM both), result-sign flag, and the 2*XLEN accumulator.
  - Special cases go IDLE->DONE directly with the result precomputed:
    - divisor 0: DIV/DIVU -> all ones; REM/REMU -> op1.
    - DIV/REM with op1=0x80000000, op2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
  - Otherwise -> BUSY, counter 0.
- BUSY: one iteration per cycle (multiply: add-if-lsb then shift right; divide: shift left, trial subtract, set quotient bit). Counter increments each cycle. When counter = XLEN-1, -> DONE with sign fixup (two's-complement negate) applied to the selected word.
  - Sign fixup: quotient negated iff operand signs differ; remainder takes the dividend's sign; products follow the sign flag.
- Word selection: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
- DONE: ready_o=1 and result_o valid for exactly one cycle, then -> IDLE unconditionally. start_i is ignored in DONE, so the held instruction does not restart.
- Latency: start in cycle 0 -> ready_o in cycle XLEN+1 (33) for the normal path, and in cycle 1 for special cases. Back-to-back operations: the next start is sampled in the IDLE cycle after DONE.
- stallreq_o (combinational):
  - 1 in IDLE with start_i=1 and flush_i=0.
  - 1 in BUSY.
  - 0 in DONE.
- Flush: flush_i=1 in BUSY or DONE -> IDLE next edge, no ready_o. flush_i=1 in IDLE blocks start. Flush has priority over start.
- Operand changes on op1_i/op2_i/funct3_i after latch are ignored.
- result_o holds its last value outside DONE and is only meaningful while ready_o=1.

Optional Feature:
MDU_EARLY_OUT_EN:
- Defined: in IDLE, a multiply with either operand 0 goes directly to DONE with result 0. A DIVU/REMU with op1 < op2 goes directly to DONE with quotient 0, remainder op1. Latency for these cases is 1.
- Undefined: these cases take the full XLEN-cycle path, with identical results.

Decomposition:
- Package mdu_pkg: funct3 constants (MUL..REMU), state encoding (IDLE/BUSY/DONE), XLEN default, helper function for conditional two's-complement negate.
- One sub-module, mdu_iter_core: the combinational single-iteration step (multiply add-shift / divide subtract-shift) on the accumulator. The sequencer owns the FSM, counter, latching and fixup.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD, start at cycle 0 -> stallreq_o high cycles 0-32; ready_o in cycle 33 with result 0xFFFFFFEB; stallreq_o 0 in cycle 33.
- High-word products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV -7 / 2 -> 0xFFFFFFFD.
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 % 7 -> 2.
- Special cases, each with ready_o in cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Abort paths:
  - flush_i pulse in cycle 10 of a DIV -> busy_o 0 from cycle 11, no ready_o; new MUL 3x4 started in cycle 11 -> 12 in cycle 44.
  - rst_i low in cycle 5 -> outputs immediately 0.
- Back-to-back: two MULs with start_i held through DONE -> second result in cycle 67, no spurious restart. With MDU_EARLY_OUT_EN, MUL 0 x 9 -> 0 in cycle 1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer (mdu_seq).
// funct3 codes, FSM state encoding, default width and the conditional
// two's-complement negate used for the result sign fixup.
package mdu_pkg;

  localparam int MDU_XLEN = 32;
  localparam int MDU_DW   = 2 * MDU_XLEN;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // Two's-complement negate of a double-width value when neg is set.
  // Narrower words are zero-extended by the caller; the low bits of the
  // negated double word equal the negated narrow word.
  function automatic logic [MDU_DW-1:0] cond_neg(input logic neg,
                                                 input logic [MDU_DW-1:0] val);
    logic [MDU_DW-1:0] res;
    if (neg) begin
      res = ~val + {{(MDU_DW-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Single iteration of the MDU datapath on the 2*XLEN accumulator.
// Multiply: acc = {hi, lo}, add b into hi when lo[0] is set, then shift the
//           whole accumulator right by one (carry enters the top bit).
// Divide:   acc = {rem, quo}, shift left by one, trial-subtract b from the
//           remainder and shift in the quotient bit (restoring scheme).
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     b,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0]       sum_s;
  logic [XLEN:0]       part_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic [XLEN:0]       trial_s;
  logic [XLEN:0]       diff_s;
  logic [2*XLEN-1:0]   div_next_s;

  // One add-shift or subtract-shift step, selected by the operation class.
  always_comb begin
    sum_s      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b};
    part_s     = {1'b0, acc[2*XLEN-1:XLEN]};
    mul_next_s = {2*XLEN{1'b0}};
    trial_s    = acc[2*XLEN-1:XLEN-1];
    diff_s     = trial_s - {1'b0, b};
    div_next_s = {2*XLEN{1'b0}};

    if (acc[0]) begin
      part_s = sum_s;
    end else begin
      part_s = {1'b0, acc[2*XLEN-1:XLEN]};
    end
    mul_next_s = {part_s, acc[XLEN-1:1]};

    // The trial value stays below 2*b, so bit XLEN of the difference is a
    // clean borrow flag.
    if (!diff_s[XLEN]) begin
      div_next_s = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {trial_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    if (is_div) begin
      acc_next = div_next_s;
    end else begin
      acc_next = mul_next_s;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer beside the execute stage.
// Latches one M-type operation, runs XLEN shift-add / restoring-divide
// iterations, presents the result for one cycle and stalls the pipeline
// meanwhile. Handles operand signs, divide-by-zero / overflow results and
// flush abort.
// Optional build macro MDU_EARLY_OUT_EN: multiplies with a zero operand and
// DIVU/REMU with op1 < op2 finish in one cycle instead of the full path.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            stallreq_o
);

  mdu_state_e          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          f3_r;
  logic                neg_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     b_r;
  logic [XLEN-1:0]     result_r;
  logic                busy_r;
  logic                ready_r;

  logic                op1_signed_s;
  logic                op2_signed_s;
  logic                s1_s;
  logic                s2_s;
  logic [XLEN-1:0]     abs1_s;
  logic [XLEN-1:0]     abs2_s;
  logic                neg_in_s;
  logic                special_s;
  logic [XLEN-1:0]     special_res_s;
  logic [2*XLEN-1:0]   acc_next_s;
  logic [MDU_DW-1:0]   prod_s;
  logic [XLEN-1:0]     quo_rem_s;
  logic [MDU_DW-1:0]   div_fix_s;
  logic [XLEN-1:0]     fix_word_s;
  logic                accept_s;

  localparam logic [XLEN-1:0]  ZERO_W    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_W    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG_W = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_iter (
    .is_div  (f3_r[2]),
    .acc     (acc_r),
    .b       (b_r),
    .acc_next(acc_next_s)
  );

  // Operand signedness, magnitudes and the result sign for the incoming op.
  always_comb begin
    op1_signed_s = 1'b0;
    op2_signed_s = 1'b0;
    case (funct3_i)
      F3_MULH: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
      end
      F3_MULHSU: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b0;
      end
      F3_DIV, F3_REM: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
      end
      default: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
      end
    endcase

    s1_s = op1_signed_s & op1_i[XLEN-1];
    s2_s = op2_signed_s & op2_i[XLEN-1];

    if (s1_s) begin
      abs1_s = ~op1_i + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      abs1_s = op1_i;
    end
    if (s2_s) begin
      abs2_s = ~op2_i + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      abs2_s = op2_i;
    end

    // Remainder follows the dividend; quotient and products follow the
    // exclusive-or of operand signs.
    if (funct3_i == F3_REM) begin
      neg_in_s = s1_s;
    end else begin
      neg_in_s = s1_s ^ s2_s;
    end
  end

  // Operations whose result is known without iterating.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = ZERO_W;
    if (funct3_i[2] && (op2_i == ZERO_W)) begin
      special_s = 1'b1;
      if (funct3_i[1]) begin
        special_res_s = op1_i;
      end else begin
        special_res_s = ONES_W;
      end
    end else if (funct3_i[2] && !funct3_i[0] &&
                 (op1_i == MIN_NEG_W) && (op2_i == ONES_W)) begin
      special_s = 1'b1;
      if (funct3_i[1]) begin
        special_res_s = ZERO_W;
      end else begin
        special_res_s = MIN_NEG_W;
      end
`ifdef MDU_EARLY_OUT_EN
    end else if (!funct3_i[2] && ((op1_i == ZERO_W) || (op2_i == ZERO_W))) begin
      special_s     = 1'b1;
      special_res_s = ZERO_W;
    end else if (funct3_i[2] && funct3_i[0] && (op1_i < op2_i)) begin
      special_s = 1'b1;
      if (funct3_i[1]) begin
        special_res_s = op1_i;
      end else begin
        special_res_s = ZERO_W;
      end
`endif
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_W;
    end
  end

  // Final-iteration word selection with the sign fixup applied.
  always_comb begin
    prod_s = cond_neg(neg_r, MDU_DW'(acc_next_s));
    if (f3_r[1]) begin
      quo_rem_s = acc_next_s[2*XLEN-1:XLEN];
    end else begin
      quo_rem_s = acc_next_s[XLEN-1:0];
    end
    div_fix_s = cond_neg(neg_r, MDU_DW'(quo_rem_s));
    if (f3_r[2]) begin
      fix_word_s = div_fix_s[XLEN-1:0];
    end else if (f3_r[1:0] == 2'b00) begin
      fix_word_s = prod_s[XLEN-1:0];
    end else begin
      fix_word_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Stall request: a pending accepted start, or an operation in flight.
  always_comb begin
    accept_s = start_i & ~flush_i;
    if (state_r == ST_BUSY) begin
      stallreq_o = 1'b1;
    end else if (state_r == ST_IDLE) begin
      stallreq_o = accept_s;
    end else begin
      stallreq_o = 1'b0;
    end
  end

  // Sequencer FSM: latch, iterate, present result, abort on flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      f3_r     <= 3'b000;
      neg_r    <= 1'b0;
      acc_r    <= {2*XLEN{1'b0}};
      b_r      <= ZERO_W;
      result_r <= ZERO_W;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            f3_r  <= funct3_i;
            neg_r <= neg_in_s;
            acc_r <= {ZERO_W, abs1_s};
            b_r   <= abs2_s;
            cnt_r <= {CNT_W{1'b0}};
            if (special_s) begin
              state_r  <= ST_DONE;
              result_r <= special_res_s;
              busy_r   <= 1'b0;
              ready_r  <= 1'b1;
            end else begin
              state_r <= ST_BUSY;
              busy_r  <= 1'b1;
              ready_r <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
              state_r  <= ST_DONE;
              result_r <= fix_word_s;
              busy_r   <= 1'b0;
              ready_r  <= 1'b1;
            end else begin
              state_r <= ST_BUSY;
              busy_r  <= 1'b1;
              ready_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // start_i is ignored here so a still-held instruction cannot restart.
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_r;
  assign ready_o  = ready_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed, table-driven bench for mdu_seq plus hand-written sequences for
// flush abort, back-to-back issue with start held, and mid-operation reset.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        ready;
  logic [31:0] result;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  mdu_seq dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .start_i   (start),
    .flush_i   (flush),
    .funct3_i  (funct3),
    .op1_i     (op1),
    .op2_i     (op2),
    .busy_o    (busy),
    .ready_o   (ready),
    .result_o  (result),
    .stallreq_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LN = 33;
  localparam int LS = 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int LE = 1;
`else
  localparam int LE = 33;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at the next cycle, hold start until ready, count stall errors.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int stall_bad);
    lat = -1;
    res = 32'h0;
    stall_bad = 0;
    @(negedge clk);
    funct3 = f3;
    op1    = a;
    op2    = b;
    start  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        op1    = $urandom;
        op2    = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
      #1;
      if (ready) begin
        lat = c;
        res = result;
        if (stall || busy) stall_bad++;
        break;
      end else begin
        if (!stall) stall_bad++;
        if (c > 0 && !busy) stall_bad++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          lat;
    int          sbad;
    int          nrdy;
    int          rc0;
    int          rc1;
    int          stray;
    logic [31:0] res;
    logic [31:0] r0;
    logic [31:0] r1;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, LN};
    vecs[1]  = '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, LN};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, LN};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, LN};
    vecs[4]  = '{3'b001, 32'hFFFFFFFD,  32'd5,        32'hFFFFFFFF, LN};
    vecs[5]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, LN};
    vecs[6]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, LN};
    vecs[7]  = '{3'b101, 32'd100,       32'd7,        32'd14,       LN};
    vecs[8]  = '{3'b111, 32'd100,       32'd7,        32'd2,        LN};
    vecs[9]  = '{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, LN};
    vecs[10] = '{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        LN};
    vecs[11] = '{3'b100, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       LN};
    vecs[12] = '{3'b110, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, LN};
    vecs[13] = '{3'b011, 32'h00010000,  32'h00010000, 32'd1,        LN};
    vecs[14] = '{3'b000, 32'h00012345,  32'h00000100, 32'h01234500, LN};
    vecs[15] = '{3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, LS};
    vecs[16] = '{3'b110, 32'd5,         32'd0,        32'd5,        LS};
    vecs[17] = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, LS};
    vecs[18] = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        LS};
    vecs[19] = '{3'b000, 32'd0,         32'd9,        32'd0,        LE};
    vecs[20] = '{3'b111, 32'd3,         32'd10,       32'd3,        LE};
    vecs[21] = '{3'b101, 32'd3,         32'd10,       32'd0,        LE};
    vecs[22] = '{3'b101, 32'h80000000,  32'hFFFFFFFF, 32'd0,        LE};

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op1    = 32'h0;
    op2    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",   {31'h0, busy},  32'h0);
    chk("rst_ready",  {31'h0, ready}, 32'h0);
    chk("rst_result", result,         32'h0);
    chk("rst_stall",  {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, res, sbad);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_stall", i), 32'(sbad), 32'd0);
    end

    // Flush in cycle 10 of a DIV, then MUL 3x4 started in cycle 11
    stray = 0;
    rc0   = -1;
    r0    = 32'h0;
    @(negedge clk);
    funct3 = 3'b100; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10) begin
        start = 1'b0;
        flush = 1'b1;
      end
      if (c == 11) begin
        flush = 1'b0;
        start = 1'b1;
        funct3 = 3'b000; op1 = 32'd3; op2 = 32'd4;
      end
      #1;
      if (c == 11) chk("flush_busy_c11", {31'h0, busy}, 32'h0);
      if (ready) begin
        if (rc0 < 0) begin
          rc0 = c;
          r0  = result;
        end else begin
          stray++;
        end
      end
    end
    start = 1'b0;
    chk("flush_ready_cycle", 32'(rc0), 32'd44);
    chk("flush_mul_result",  r0,       32'd12);
    chk("flush_stray_ready", 32'(stray), 32'd0);

    // Back-to-back MULs with start held through DONE
    nrdy = 0;
    rc0 = -1; rc1 = -1;
    r0 = 32'h0; r1 = 32'h0;
    @(negedge clk);
    funct3 = 3'b000; op1 = 32'd5; op2 = 32'd6; start = 1'b1;
    for (int c = 0; c <= 67; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 34) begin
        op1 = 32'd7;
        op2 = 32'd8;
      end
      #1;
      if (ready) begin
        if (nrdy == 0) begin
          rc0 = c;
          r0  = result;
        end else if (nrdy == 1) begin
          rc1 = c;
          r1  = result;
        end else begin
          rc1 = -2;
        end
        nrdy++;
      end
    end
    start = 1'b0;
    chk("b2b_ready_count",  32'(nrdy), 32'd2);
    chk("b2b_first_cycle",  32'(rc0),  32'd33);
    chk("b2b_first_result", r0,        32'd30);
    chk("b2b_second_cycle", 32'(rc1),  32'd67);
    chk("b2b_second_result", r1,       32'd56);

    // Asynchronous reset in cycle 5 of an operation
    @(negedge clk);
    funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
    end
    chk("midrst_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midrst_busy",   {31'h0, busy},  32'h0);
    chk("midrst_ready",  {31'h0, ready}, 32'h0);
    chk("midrst_result", result,         32'h0);
    chk("midrst_stall",  {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Operation still works after the reset
    run_op(3'b000, 32'd3, 32'd4, lat, res, sbad);
    chk("post_rst_latency", 32'(lat), 32'd33);
    chk("post_rst_result",  res,      32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
